// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the branch resolution unit: op/funct3 codes, FSM states, result flags.
package branch_resolve_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_BRANCH = 2'b00,
    OP_JAL    = 2'b01,
    OP_JALR   = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
    logic misalign;
    logic cmp_err;
    logic is_br;
  } res_flags_t;

  // funct3 010/011 have no branch meaning.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational branch condition: selects the comparator flag for funct3 and
// flags an inconsistent flag set from the comparator.
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lts,
  input  logic       gtes,
  input  logic       ltu,
  input  logic       gteu,
  output logic       taken,
  output logic       cmp_err
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lts;
      F3_BGE:  taken = gtes;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = gteu;
      default: taken = 1'b0;
    endcase
  end

  // Complementary flag pairs must disagree, and equality excludes less-than.
  assign cmp_err = (lts == gtes) || (ltu == gteu) || (eq && (lts || ltu));

endmodule

// File: rtl/branch_resolve.sv
// Resolves branches/jumps into a single registered result stage (1 cycle latency,
// held under res_ready backpressure) and requests a timed pipeline flush on mispredict.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_w_i,
  output logic            ready_w_o,
  input  logic [1:0]      op_w_i,
  input  logic [2:0]      funct3_w_i,
  input  logic [XLEN-1:0] pc_w_i,
  input  logic [XLEN-1:0] imm_w_i,
  input  logic [XLEN-1:0] rs1_w_i,
  input  logic            eq_w_i,
  input  logic            lts_w_i,
  input  logic            gtes_w_i,
  input  logic            ltu_w_i,
  input  logic            gteu_w_i,
  input  logic            pred_taken_w_i,
  output logic            res_valid_w_o_h,
  input  logic            res_ready_w_i,
  output logic            taken_w_o_h,
  output logic            mispredict_w_o_h,
  output logic            illegal_w_o_h,
  output logic            misalign_w_o_h,
  output logic            cmp_err_w_o_h,
  output logic [XLEN-1:0] target_w_o,
  output logic [XLEN-1:0] link_w_o,
  output logic            flush_w_o_h,
  output logic [31:0]     br_cnt_w_o,
  output logic [31:0]     mispred_cnt_w_o
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e          state;
  logic [3:0]      flush_cnt;
  res_flags_t      res_q;
  res_flags_t      res_d;
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] link_d;
  logic [XLEN-1:0] jalr_sum;
  logic            cond_taken;
  logic            cond_cmp_err;
  logic            op_br;
  logic            accept;
  logic            out_hs;

  branch_cond u_cond (
    .funct3  (funct3_w_i),
    .eq      (eq_w_i),
    .lts     (lts_w_i),
    .gtes    (gtes_w_i),
    .ltu     (ltu_w_i),
    .gteu    (gteu_w_i),
    .taken   (cond_taken),
    .cmp_err (cond_cmp_err)
  );

  assign ready_w_o = !rst_i && (state == ST_RUN) && (!res_valid_w_o_h || res_ready_w_i);
  assign accept    = valid_w_i && ready_w_o;
  assign out_hs    = res_valid_w_o_h && res_ready_w_i;

  assign op_br    = (op_w_i == OP_BRANCH);
  assign jalr_sum = rs1_w_i + imm_w_i;
  assign target_d = (op_w_i == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_w_i + imm_w_i);
  assign link_d   = pc_w_i + XLEN'(4);

  always_comb begin
    res_d            = '0;
    res_d.illegal    = (op_w_i == OP_RSVD) || (op_br && f3_illegal(funct3_w_i));
    res_d.taken      = !res_d.illegal && (op_br ? cond_taken : 1'b1);
    res_d.misalign   = res_d.taken && target_d[1];
    res_d.cmp_err    = op_br && cond_cmp_err;
    res_d.mispredict = !res_d.illegal && (res_d.taken != pred_taken_w_i);
    res_d.is_br      = op_br && !res_d.illegal;
  end

  assign taken_w_o_h      = res_q.taken;
  assign mispredict_w_o_h = res_q.mispredict;
  assign illegal_w_o_h    = res_q.illegal;
  assign misalign_w_o_h   = res_q.misalign;
  assign cmp_err_w_o_h    = res_q.cmp_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_RUN;
      flush_cnt       <= '0;
      flush_w_o_h     <= 1'b0;
      res_valid_w_o_h <= 1'b0;
      res_q           <= '0;
      target_w_o      <= '0;
      link_w_o        <= '0;
      br_cnt_w_o      <= '0;
      mispred_cnt_w_o <= '0;
    end else begin
      if (accept) begin
        res_valid_w_o_h <= 1'b1;
        res_q           <= res_d;
        target_w_o      <= target_d;
        link_w_o        <= link_d;
      end else if (out_hs) begin
        res_valid_w_o_h <= 1'b0;
      end

      if (out_hs && res_q.is_br)      br_cnt_w_o      <= br_cnt_w_o + 32'd1;
      if (out_hs && res_q.mispredict) mispred_cnt_w_o <= mispred_cnt_w_o + 32'd1;

      // Only a mispredict retired in RUN starts a flush; results draining during
      // a flush are wrong-path and do not re-arm it.
      case (state)
        ST_RUN: begin
          if (out_hs && res_q.mispredict) begin
            state       <= ST_FLUSH;
            flush_w_o_h <= 1'b1;
            flush_cnt   <= '0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state       <= ST_RUN;
            flush_w_o_h <= 1'b0;
            flush_cnt   <= '0;
          end else begin
            flush_cnt <= flush_cnt + 4'd1;
          end
        end
        default: begin
          state       <= ST_RUN;
          flush_w_o_h <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed vector bench for branch_resolve: table of hand-computed results plus
// backpressure and reset-during-flush sequences.
module tb_branch_resolve;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [1:0]  op;
  logic [2:0]  f3;
  logic [31:0] pc, imm, rs1;
  logic        eq, lts, gtes, ltu, gteu, pred;
  logic        res_valid, res_ready;
  logic        taken, mispred, illegal, misalign, cmp_err;
  logic [31:0] target, link;
  logic        flush;
  logic [31:0] br_cnt, mp_cnt;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(FLUSH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .valid_w_i        (valid),
    .ready_w_o        (ready),
    .op_w_i           (op),
    .funct3_w_i       (f3),
    .pc_w_i           (pc),
    .imm_w_i          (imm),
    .rs1_w_i          (rs1),
    .eq_w_i           (eq),
    .lts_w_i          (lts),
    .gtes_w_i         (gtes),
    .ltu_w_i          (ltu),
    .gteu_w_i         (gteu),
    .pred_taken_w_i   (pred),
    .res_valid_w_o_h  (res_valid),
    .res_ready_w_i    (res_ready),
    .taken_w_o_h      (taken),
    .mispredict_w_o_h (mispred),
    .illegal_w_o_h    (illegal),
    .misalign_w_o_h   (misalign),
    .cmp_err_w_o_h    (cmp_err),
    .target_w_o       (target),
    .link_w_o         (link),
    .flush_w_o_h      (flush),
    .br_cnt_w_o       (br_cnt),
    .mispred_cnt_w_o  (mp_cnt)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1;
    logic [4:0]  fl;   // {eq, lts, gtes, ltu, gteu}
    logic        pred;
    logic        tk, mp, il, ma, ce;
    logic [31:0] tgt, lnk;
  } vec_t;

  vec_t        vt[14];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_br = 32'd0;
  logic [31:0] exp_mp = 32'd0;
  logic [31:0] fl_len, rdy_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op   = v.op;
    f3   = v.f3;
    pc   = v.pc;
    imm  = v.imm;
    rs1  = v.rs1;
    {eq, lts, gtes, ltu, gteu} = v.fl;
    pred = v.pred;
  endtask

  task automatic check_res(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    check({t, "_res_valid"},  32'(res_valid), 32'd1);
    check({t, "_taken"},      32'(taken),     32'(v.tk));
    check({t, "_mispredict"}, 32'(mispred),   32'(v.mp));
    check({t, "_illegal"},    32'(illegal),   32'(v.il));
    check({t, "_misalign"},   32'(misalign),  32'(v.ma));
    check({t, "_cmp_err"},    32'(cmp_err),   32'(v.ce));
    check({t, "_target"},     target,         v.tgt);
    check({t, "_link"},       link,           v.lnk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          op     f3      pc             imm            rs1            fl        pred  tk    mp    il    ma    ce    tgt            lnk
    vt[0]  = '{2'b00, 3'b000, 32'h0000_0100, 32'h0000_0020, 32'h0,         5'b10101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0120, 32'h0000_0104};
    vt[1]  = '{2'b00, 3'b001, 32'h0000_0200, 32'hFFFF_FFF0, 32'h0,         5'b10101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_01F0, 32'h0000_0204};
    vt[2]  = '{2'b00, 3'b100, 32'h0000_1000, 32'h0000_0008, 32'h0,         5'b01010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1008, 32'h0000_1004};
    vt[3]  = '{2'b00, 3'b101, 32'h0000_0010, 32'h0000_0006, 32'h0,         5'b00110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0016, 32'h0000_0014};
    vt[4]  = '{2'b00, 3'b110, 32'h0000_0300, 32'h0000_0040, 32'h0,         5'b00101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0340, 32'h0000_0304};
    vt[5]  = '{2'b00, 3'b111, 32'h0000_0400, 32'h0000_0100, 32'h0,         5'b00101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0404};
    vt[6]  = '{2'b01, 3'b000, 32'h0000_2000, 32'h0000_07FC, 32'h0,         5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_27FC, 32'h0000_2004};
    vt[7]  = '{2'b10, 3'b000, 32'hFFFF_FFFC, 32'h0000_0003, 32'hFFFF_FFFF, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0000};
    vt[8]  = '{2'b10, 3'b000, 32'h0000_0050, 32'h0000_0000, 32'h0000_1001, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_0054};
    vt[9]  = '{2'b00, 3'b010, 32'h0000_0060, 32'h0000_0004, 32'h0,         5'b10101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0000_0064};
    vt[10] = '{2'b11, 3'b000, 32'h0000_0070, 32'h0000_0010, 32'h0,         5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_0074};
    vt[11] = '{2'b00, 3'b000, 32'h0000_0080, 32'h0000_0008, 32'h0,         5'b11101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0088, 32'h0000_0084};
    vt[12] = '{2'b00, 3'b011, 32'h0000_0000, 32'h0000_0000, 32'h0,         5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004};
    vt[13] = '{2'b00, 3'b100, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,         5'b01010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'hFFFF_FFF4};

    rst       = 1'b1;
    valid     = 1'b0;
    res_ready = 1'b1;
    drive(vt[0]);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_flush",     32'(flush),     32'd0);
    check("rst_ready",     32'(ready),     32'd0);
    check("rst_taken",     32'(taken),     32'd0);
    check("rst_target",    target,         32'd0);
    check("rst_br_cnt",    br_cnt,         32'd0);
    check("rst_mp_cnt",    mp_cnt,         32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(ready), 32'd1);

    // Vector table, one request at a time, result drained immediately
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_ready", i),  32'(ready), 32'd1);
      check($sformatf("v%0d_br_cnt", i), br_cnt,     exp_br);
      check($sformatf("v%0d_mp_cnt", i), mp_cnt,     exp_mp);
      drive(vt[i]);
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      check_res(i, vt[i]);
      if (vt[i].op == 2'b00 && !vt[i].il) exp_br = exp_br + 32'd1;
      if (vt[i].mp) exp_mp = exp_mp + 32'd1;
      fl_len  = 32'd0;
      rdy_bad = 32'd0;
      repeat (4) begin
        @(negedge clk);
        if (flush) fl_len = fl_len + 32'd1;
        if (flush && ready) rdy_bad = rdy_bad + 32'd1;
      end
      check($sformatf("v%0d_flush_len", i),  fl_len,  vt[i].mp ? 32'(FLUSH) : 32'd0);
      check($sformatf("v%0d_rdy_flush", i),  rdy_bad, 32'd0);
      check($sformatf("v%0d_drained", i),    32'(res_valid), 32'd0);
    end
    @(negedge clk);
    check("tbl_br_cnt", br_cnt, exp_br);
    check("tbl_mp_cnt", mp_cnt, exp_mp);

    // Backpressure: result held, no acceptance, no counting
    res_ready = 1'b0;
    drive(vt[0]);
    valid = 1'b1;
    @(negedge clk);
    check("bp_valid",  32'(res_valid), 32'd1);
    check("bp_ready0", 32'(ready),     32'd0);
    drive(vt[6]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_ready", c),  32'(ready), 32'd0);
      check($sformatf("bp%0d_target", c), target,     32'h0000_0120);
      check($sformatf("bp%0d_link", c),   link,       32'h0000_0104);
      check($sformatf("bp%0d_br_cnt", c), br_cnt,     exp_br);
    end
    res_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(ready), 32'd1);
    @(negedge clk);
    exp_br = exp_br + 32'd1;
    check("bp_b_target", target,         32'h0000_27FC);
    check("bp_b_valid",  32'(res_valid), 32'd1);
    check("bp_b_br_cnt", br_cnt,         exp_br);
    check("bp_b_ready",  32'(ready),     32'd1);
    drive(vt[2]);
    @(negedge clk);
    valid = 1'b0;
    check("bp_c_target", target, 32'h0000_1008);
    check("bp_c_br_cnt", br_cnt, exp_br);
    @(negedge clk);
    exp_br = exp_br + 32'd1;
    check("bp_end_valid",  32'(res_valid), 32'd0);
    check("bp_end_br_cnt", br_cnt,         exp_br);
    check("bp_end_mp_cnt", mp_cnt,         exp_mp);

    // Reset asserted on the first flush cycle
    @(negedge clk);
    drive(vt[4]);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("rf_mispredict", 32'(mispred), 32'd1);
    @(negedge clk);
    check("rf_flush_on",  32'(flush), 32'd1);
    check("rf_ready_off", 32'(ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rf_flush",     32'(flush),     32'd0);
    check("rf_res_valid", 32'(res_valid), 32'd0);
    check("rf_br_cnt",    br_cnt,         32'd0);
    check("rf_mp_cnt",    mp_cnt,         32'd0);
    check("rf_ready",     32'(ready),     32'd1);
    @(negedge clk);
    check("rf_flush_stays_off", 32'(flush), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 Parameter: FLUSH_CYCLES, 2, cycles flush_w_o_h is held after a mispredict (legal range 1-15).
REQ-003 Port: clk_i  in  1  sole clock; every state element updates on the rising edge.
REQ-004 Port: rst_i  in  1  reset, synchronous and active-high.
REQ-005 Port: valid_w_i / ready_w_o  in/out  1/1  request handshake; a request is accepted when both are high on a rising edge.
REQ-006 Port: op_w_i  in  2  00 conditional branch, 01 JAL, 10 JALR, 11 reserved.
REQ-007 Port: funct3_w_i  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-008 Port: pc_w_i, imm_w_i, rs1_w_i  in  XLEN each  instruction PC, sign-extended immediate, JALR base.
REQ-009 Port: eq_w_i, lts_w_i, gtes_w_i, ltu_w_i, gteu_w_i  in  1 each  comparator flags for rs1 vs rs2.
REQ-010 Port: pred_taken_w_i  in  1  front-end prediction for this instruction.
REQ-011 Port: res_valid_w_o_h / res_ready_w_i  out/in  1/1  result handshake.
REQ-012 Port: taken_w_o_h, mispredict_w_o_h, illegal_w_o_h, misalign_w_o_h, cmp_err_w_o_h  out  1 each  registered result flags.
REQ-013 Port: target_w_o, link_w_o  out  XLEN each  resolved target and PC+4.
REQ-014 Port: flush_w_o_h  out  1  pipeline flush request.
REQ-015 Port: br_cnt_w_o, mispred_cnt_w_o  out  32 each  resolved-branch and mispredict counters.

Function
REQ-016 Taken: BEQ=eq, BNE=!eq, BLT=lts, BGE=gtes, BLTU=ltu, BGEU=gteu; JAL and JALR always taken.
REQ-017 op 11 and funct3 010/011 with op 00 set illegal_w_o_h=1 and taken_w_o_h=0; mispredict_w_o_h=0.
REQ-018 Target: op 00/01 = pc+imm; op 10 = (rs1+imm) with bit 0 cleared; both modulo 2^XLEN with silent wrap-around.
REQ-019 link_w_o = pc+4 modulo 2^XLEN for every op.
REQ-020 misalign_w_o_h = taken AND target[1]; taken_w_o_h still reported.
REQ-021 cmp_err_w_o_h = (lts==gtes) OR (ltu==gteu) OR (eq AND (lts OR ltu)), sampled on op 00 only; the result is otherwise computed normally.
REQ-022 mispredict_w_o_h = !illegal AND (taken != pred_taken_w_i).
REQ-023 Single output register: result appears on res_valid_w_o_h one cycle after acceptance and is held stable while res_ready_w_i is low.
REQ-024 ready_w_o = (state==RUN) AND (!res_valid_w_o_h OR res_ready_w_i); back-to-back throughput is one request per cycle.
REQ-025 FSM states: RUN, FLUSH. RUN->FLUSH when a result with mispredict_w_o_h=1 completes its output handshake; FLUSH->RUN after FLUSH_CYCLES cycles.
REQ-026 In FLUSH: flush_w_o_h=1, ready_w_o=0, and valid_w_i is ignored. flush_w_o_h=0 in RUN.
REQ-027 br_cnt increments on each output handshake with op 00 and not illegal; mispred_cnt increments on each handshake with mispredict=1; both wrap from FFFF_FFFF to 0.

Reset
REQ-028 While rst_i=1 at a clock edge: state=RUN, flush counter=0, all outputs=0 (ready_w_o=1 after release), counters=0; any in-flight result is discarded.
REQ-029 Reset asserted during FLUSH terminates the flush on the same edge.

Structure
REQ-030 Shared package holds op encodings, funct3 encodings, the FSM state enum, and the XLEN default.
REQ-031 Sub-module branch_cond, combinational, maps funct3 and the flags to taken and cmp_err; all other logic is in branch_resolve.

Verification
REQ-032 BEQ with eq=1, pc=0x100, imm=0x20, pred=1, res_ready=1 -> next cycle: taken=1, target=0x120, link=0x104, mispredict=0, br_cnt=1.
REQ-033 BLTU with ltu=0, gteu=1, pred=1 -> taken=0, mispredict=1, flush high for exactly 2 cycles after the handshake, ready_w_o low for those cycles, mispred_cnt=1.
REQ-034 JALR with rs1=0xFFFF_FFFF, imm=0x3 -> target=0x0000_0002, misalign=1, taken=1; pc=0xFFFF_FFFC -> link=0x0.
REQ-035 res_ready held low for 3 cycles with valid_w_i high -> ready_w_o=0, outputs stable, no counter change; on release, exactly one handshake and then back-to-back acceptance.
REQ-036 funct3=010 with op 00 -> illegal=1, taken=0, no flush, br_cnt unchanged; flags lts=gtes=1 on BEQ -> cmp_err=1.
REQ-037 rst_i asserted on the first FLUSH cycle -> next cycle: flush=0, res_valid=0, counters=0, ready_w_o=1.
